hdma_bus_port: RTL and testbench

HDMA_BUS_PORT -- requirements
Module: hdma_bus_port

---
 rtl/hdma_bus_port.sv | 158 +++++++++++++++
 tb/tb_hdma_bus_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdma_bus_port.sv
// HDMA bus port: fetches each byte the upstream HDMA engine asks for from the
// source bus and writes it into VRAM.
// - Holds off while the PPU has VRAM locked.
// - Stalls the CPU while the engine owns the bus or a byte is still in flight.
module hdma_bus_port (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        dma_active,
    input  logic        dma_rd,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic [1:0]  lcd_mode,
    output logic        vram_wr,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        cpu_stall,
    output logic [10:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] last_key;
    logic [12:0] wr_addr;
    logic        skip_rd;
    logic        rd_prev;
    logic        act_prev;
    logic        blocked;

    logic [31:0] key;
    logic        rd_rise;
    logic        act_rise;
    logic        act_fall;
    logic        key_changed;
    logic        src_skip;
    logic        vram_locked;
    logic        trigger;
    logic        start;

    assign key      = {src_addr, dst_addr};
    assign rd_rise  = dma_rd & ~rd_prev;
    assign act_rise = dma_active & ~act_prev;
    assign act_fall = ~dma_active & act_prev;

    // A dma_active rising edge clears last_key in this same ce.
    // So the comparison is made against the cleared value.
    assign key_changed = act_rise ? (key != 32'hFFFF_FFFF) : (key != last_key);

    // VRAM (0x8000-0x9FFF) and echo/IO space (>= 0xE000) are not readable
    // sources. Those bytes are written as 0xFF without touching the bus.
    assign src_skip = (src_addr[15:13] == 3'b100) || (src_addr[15:13] == 3'b111);

    assign vram_locked = (lcd_mode == 2'd3);

    // A fresh dma_rd edge always triggers.
    // Otherwise a new key triggers unless a dma_active drop has blocked the
    // engine until dma_rd rises again.
    assign trigger = dma_rd & (rd_rise | (key_changed & ~blocked & ~act_fall));

    // Start a byte from IDLE, or chain one directly behind a completing
    // write. This keeps back-to-back bytes at two ce cycles each.
    assign start = trigger &
                   ((state == IDLE) | ((state == WRITE) & ~vram_locked));

    // Transfer FSM with all outputs registered; nothing moves unless ce=1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= 16'h0000;
            vram_wr    <= 1'b0;
            vram_addr  <= 13'h0000;
            vram_wdata <= 8'hFF;
            cpu_stall  <= 1'b0;
            byte_count <= 11'h000;
            last_key   <= 32'hFFFF_FFFF;
            wr_addr    <= 13'h0000;
            skip_rd    <= 1'b0;
            rd_prev    <= 1'b0;
            act_prev   <= 1'b0;
            blocked    <= 1'b0;
        end else if (ce) begin
            rd_prev  <= dma_rd;
            act_prev <= dma_active;
            vram_wr  <= 1'b0;

            if (rd_rise) begin
                blocked <= 1'b0;
            end else if (act_fall) begin
                blocked <= 1'b1;
            end

            if (act_rise) begin
                byte_count <= 11'h000;
                last_key   <= 32'hFFFF_FFFF;
            end

            case (state)
                IDLE: begin
                    cpu_stall <= dma_active;
                end
                READ: begin
                    if (skip_rd) begin
                        vram_wdata <= 8'hFF;
                        vram_addr  <= wr_addr;
                        state      <= WRITE;
                    end else if (mem_ack) begin
                        vram_wdata <= mem_rdata;
                        vram_addr  <= wr_addr;
                        mem_req    <= 1'b0;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (vram_locked) begin
                        state <= HOLD;
                    end else begin
                        vram_wr <= 1'b1;
                        if (!act_rise && (byte_count != 11'h7FF)) begin
                            byte_count <= byte_count + 11'd1;
                        end
                        state     <= IDLE;
                        cpu_stall <= dma_active;
                    end
                end
                HOLD: begin
                    if (!vram_locked) begin
                        state <= WRITE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (start) begin
                state     <= READ;
                mem_req   <= ~src_skip;
                mem_addr  <= src_addr;
                wr_addr   <= dst_addr[12:0];
                skip_rd   <= src_skip;
                last_key  <= key;
                cpu_stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdma_bus_port.sv
// Directed bench for hdma_bus_port. The bench steps ce one clock in two, so
// each ce period is two clk cycles. Outputs are sampled 1 ns after each edge.
module tb_hdma_bus_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        dma_active;
    logic        dma_rd;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [1:0]  lcd_mode;
    logic        vram_wr;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        cpu_stall;
    logic [10:0] byte_count;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int req_cnt = 0;
    int base_s;
    int base_r;

    hdma_bus_port dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .dma_active (dma_active),
        .dma_rd     (dma_rd),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .lcd_mode   (lcd_mode),
        .vram_wr    (vram_wr),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .cpu_stall  (cpu_stall),
        .byte_count (byte_count)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Count completed VRAM strobes and bus-request cycles on enabled edges
    always @(posedge clk) begin
        if (reset_n && ce) begin
            if (vram_wr) strobe_cnt++;
            if (mem_req) req_cnt++;
        end
    end

    task automatic apply_stimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); ce = 1'b1;
            @(posedge clk); #1;
            @(negedge clk); ce = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_mem_req"},    32'(mem_req),    32'h0);
        check_output({tag, "_vram_wr"},    32'(vram_wr),    32'h0);
        check_output({tag, "_cpu_stall"},  32'(cpu_stall),  32'h0);
        check_output({tag, "_mem_addr"},   32'(mem_addr),   32'h0000);
        check_output({tag, "_vram_addr"},  32'(vram_addr),  32'h0000);
        check_output({tag, "_vram_wdata"}, 32'(vram_wdata), 32'hFF);
        check_output({tag, "_byte_count"}, 32'(byte_count), 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; dma_active = 1'b0; dma_rd = 1'b0;
        src_addr = 16'h0; dst_addr = 16'h0; mem_rdata = 8'h0;
        mem_ack = 1'b0; lcd_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk); reset_n = 1'b1; ce = 1'b0;

        $display("[TB] basic byte");
        dma_active = 1'b1; src_addr = 16'h2040; dst_addr = 16'h8200;
        mem_rdata = 8'h5A; mem_ack = 1'b1;
        apply_stimulus(1);
        check_output("basic_stall", 32'(cpu_stall), 32'h1);
        base_s = strobe_cnt;
        dma_rd = 1'b1;
        apply_stimulus(1);
        check_output("basic_req",   32'(mem_req),  32'h1);
        check_output("basic_maddr", 32'(mem_addr), 32'h2040);
        check_output("basic_nowr0", 32'(vram_wr),  32'h0);
        apply_stimulus(1);
        check_output("basic_reqoff", 32'(mem_req), 32'h0);
        check_output("basic_nowr1",  32'(vram_wr), 32'h0);
        apply_stimulus(1);
        check_output("basic_wr",    32'(vram_wr),    32'h1);
        check_output("basic_vaddr", 32'(vram_addr),  32'h0200);
        check_output("basic_data",  32'(vram_wdata), 32'h5A);
        check_output("basic_count", 32'(byte_count), 32'h1);
        mem_ack = 1'b0;
        apply_stimulus(4);
        check_output("basic_nodup",  32'(strobe_cnt - base_s), 32'h1);
        check_output("basic_wroff",  32'(vram_wr),   32'h0);
        check_output("basic_noreq",  32'(mem_req),   32'h0);
        check_output("basic_stall2", 32'(cpu_stall), 32'h1);

        $display("[TB] 16-byte block");
        dma_rd = 1'b0; dma_active = 1'b0;
        apply_stimulus(1);
        check_output("blk_stall_off", 32'(cpu_stall), 32'h0);
        dma_active = 1'b1;
        apply_stimulus(1);
        check_output("blk_count_clr", 32'(byte_count), 32'h0);
        base_s = strobe_cnt;
        mem_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src_addr = 16'h3000 + 16'(i); dst_addr = 16'h8200 + 16'(i);
            mem_rdata = 8'h10 + 8'(i); dma_rd = 1'b1;
            apply_stimulus(1);
            if (i > 0) begin
                check_output("blk_wr",    32'(vram_wr),    32'h1);
                check_output("blk_vaddr", 32'(vram_addr),  32'h200 + 32'(i) - 32'h1);
                check_output("blk_data",  32'(vram_wdata), 32'h10 + 32'(i) - 32'h1);
            end
            apply_stimulus(1);
        end
        apply_stimulus(1);
        check_output("blk_last_wr",    32'(vram_wr),    32'h1);
        check_output("blk_last_vaddr", 32'(vram_addr),  32'h020F);
        check_output("blk_last_data",  32'(vram_wdata), 32'h1F);
        check_output("blk_count",      32'(byte_count), 32'h10);
        check_output("blk_stall_on",   32'(cpu_stall),  32'h1);
        dma_rd = 1'b0; dma_active = 1'b0; mem_ack = 1'b0;
        apply_stimulus(1);
        check_output("blk_stall_fall", 32'(cpu_stall), 32'h0);
        check_output("blk_wroff",      32'(vram_wr),   32'h0);
        check_output("blk_strobes",    32'(strobe_cnt - base_s), 32'h10);

        $display("[TB] VRAM lock");
        src_addr = 16'h4000; dst_addr = 16'h9ABC; mem_rdata = 8'hC3;
        mem_ack = 1'b1; dma_active = 1'b1;
        apply_stimulus(1);
        base_s = strobe_cnt;
        dma_rd = 1'b1;
        apply_stimulus(1);
        lcd_mode = 2'd3;
        apply_stimulus(1);
        apply_stimulus(10);
        check_output("lock_nowr",    32'(vram_wr),    32'h0);
        check_output("lock_nostrb",  32'(strobe_cnt - base_s), 32'h0);
        check_output("lock_stall",   32'(cpu_stall),  32'h1);
        check_output("lock_hold_d",  32'(vram_wdata), 32'hC3);
        check_output("lock_hold_a",  32'(vram_addr),  32'h1ABC);
        lcd_mode = 2'd0;
        apply_stimulus(1);
        check_output("lock_exit_nowr", 32'(vram_wr), 32'h0);
        apply_stimulus(1);
        check_output("lock_wr",    32'(vram_wr),    32'h1);
        check_output("lock_vaddr", 32'(vram_addr),  32'h1ABC);
        check_output("lock_data",  32'(vram_wdata), 32'hC3);
        check_output("lock_count", 32'(byte_count), 32'h1);
        apply_stimulus(2);
        check_output("lock_single", 32'(strobe_cnt - base_s), 32'h1);
        dma_rd = 1'b0; mem_ack = 1'b0;
        apply_stimulus(1);

        $display("[TB] invalid sources");
        src_addr = 16'h8123; dst_addr = 16'h8010; mem_rdata = 8'h77;
        base_s = strobe_cnt; base_r = req_cnt;
        dma_rd = 1'b1;
        apply_stimulus(1);
        check_output("inv_noreq", 32'(mem_req),  32'h0);
        check_output("inv_maddr", 32'(mem_addr), 32'h8123);
        apply_stimulus(2);
        check_output("inv_wr",    32'(vram_wr),    32'h1);
        check_output("inv_data",  32'(vram_wdata), 32'hFF);
        check_output("inv_vaddr", 32'(vram_addr),  32'h0010);
        check_output("inv_count", 32'(byte_count), 32'h2);
        dma_rd = 1'b0;
        apply_stimulus(1);
        src_addr = 16'hE000; dst_addr = 16'h8011;
        dma_rd = 1'b1;
        apply_stimulus(1);
        check_output("inv_e000_noreq", 32'(mem_req), 32'h0);
        apply_stimulus(2);
        check_output("inv_e000_data",  32'(vram_wdata), 32'hFF);
        check_output("inv_e000_vaddr", 32'(vram_addr),  32'h0011);
        check_output("inv_e000_count", 32'(byte_count), 32'h3);
        dma_rd = 1'b0;
        apply_stimulus(1);
        check_output("inv_reqcnt", 32'(req_cnt - base_r),    32'h0);
        check_output("inv_strobes", 32'(strobe_cnt - base_s), 32'h2);

        $display("[TB] slow bus");
        src_addr = 16'h1234; dst_addr = 16'h8555; mem_rdata = 8'hA7;
        mem_ack = 1'b0;
        base_s = strobe_cnt; base_r = req_cnt;
        dma_rd = 1'b1;
        apply_stimulus(1);
        check_output("slow_req", 32'(mem_req), 32'h1);
        apply_stimulus(2);
        dma_rd = 1'b0;
        apply_stimulus(2);
        check_output("slow_req_held", 32'(mem_req), 32'h1);
        check_output("slow_nowr",     32'(vram_wr), 32'h0);
        mem_ack = 1'b1;
        apply_stimulus(1);
        check_output("slow_reqoff", 32'(mem_req), 32'h0);
        mem_ack = 1'b0;
        apply_stimulus(1);
        check_output("slow_wr",    32'(vram_wr),    32'h1);
        check_output("slow_data",  32'(vram_wdata), 32'hA7);
        check_output("slow_vaddr", 32'(vram_addr),  32'h0555);
        check_output("slow_count", 32'(byte_count), 32'h4);
        apply_stimulus(3);
        check_output("slow_strobes", 32'(strobe_cnt - base_s), 32'h1);
        check_output("slow_reqcnt",  32'(req_cnt - base_r),    32'h5);
        check_output("slow_idle_wr", 32'(vram_wr), 32'h0);

        $display("[TB] reset in HOLD");
        src_addr = 16'h2000; dst_addr = 16'h8777; mem_rdata = 8'h11;
        mem_ack = 1'b1;
        base_s = strobe_cnt;
        dma_rd = 1'b1;
        apply_stimulus(1);
        lcd_mode = 2'd3;
        apply_stimulus(3);
        check_output("hold_stall", 32'(cpu_stall), 32'h1);
        check_output("hold_nowr",  32'(vram_wr),   32'h0);
        @(negedge clk); reset_n = 1'b0; ce = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset_n = 1'b1; ce = 1'b0; dma_rd = 1'b0; dma_active = 1'b0;
        lcd_mode = 2'd0; mem_ack = 1'b0;
        check_reset_values("hold_rst");
        apply_stimulus(3);
        check_output("hold_nostrb", 32'(strobe_cnt - base_s), 32'h0);
        check_output("hold_idle_stall", 32'(cpu_stall), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
